gf180mcu_fd_sc_mcu9t5v0__clkdiv: RTL

- Parametrised, registered clock-divider buffer: the successor to the plain clock buffer cell.
- Produces a divided clock Z from CLK with a programmable ratio, glitch-free start/stop and glitch-free ratio change.
- Also produces a period-start strobe for local synchronous logic.
- Used in MCU clock trees where a slow peripheral clock is derived from the core clock without external gating cells.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_if.sv | 13 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv.sv | 104 ++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_if.sv
// Clock-divider control/status bundle: run request and ratio in, divided clock and strobes out.
interface gf180mcu_fd_sc_mcu9t5v0__clkdiv_if #(
    parameter int unsigned W = 8
) ();
    logic         EN;
    logic [W-1:0] DIV;
    logic         Z;
    logic         TICK;
    logic         ACTIVE;

    modport master (output EN, output DIV, input Z, input TICK, input ACTIVE);
    modport slave  (input EN, input DIV, output Z, output TICK, output ACTIVE);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv.sv
// Registered clock divider: flop-driven Z with programmable ratio, period-start TICK and
// glitch-free start/stop and ratio change (ratio and run request only act at period boundaries).
module gf180mcu_fd_sc_mcu9t5v0__clkdiv #(
    parameter int unsigned W = 8
) (
    input logic                              CLK,
    input logic                              RN,
    gf180mcu_fd_sc_mcu9t5v0__clkdiv_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic [W-1:0] r_q, r_q_nxt;
    logic         z, z_nxt;
    logic         tick, tick_nxt;
    logic         active, active_nxt;

    logic [W:0]   h_c;
    logic [W:0]   cnt_inc_c;
    logic [W-1:0] div_clamp_c;
    logic         last_c;

    // One extra bit so ceil(R_q/2) and cnt+1 cannot overflow at the maximum ratio.
    assign h_c         = ((W+1)'(r_q) + (W+1)'(1)) >> 1;
    assign cnt_inc_c   = (W+1)'(cnt) + (W+1)'(1);
    assign div_clamp_c = (bus.DIV < W'(2)) ? W'(2) : bus.DIV;
    assign last_c      = (cnt == (r_q - W'(1)));

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state  <= IDLE;
            cnt    <= '0;
            r_q    <= W'(2);
            z      <= 1'b0;
            tick   <= 1'b0;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            r_q    <= r_q_nxt;
            z      <= z_nxt;
            tick   <= tick_nxt;
            active <= active_nxt;
        end
    end

    // Next-state: EN and DIV are only honoured in IDLE or on the last cycle of a period.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        r_q_nxt    = r_q;
        z_nxt      = z;
        tick_nxt   = tick;
        active_nxt = active;

        case (state)
            IDLE: begin
                z_nxt      = 1'b0;
                tick_nxt   = 1'b0;
                active_nxt = 1'b0;
                if (bus.EN) begin
                    state_nxt  = RUN;
                    cnt_nxt    = '0;
                    r_q_nxt    = div_clamp_c;
                    z_nxt      = 1'b1;
                    tick_nxt   = 1'b1;
                    active_nxt = 1'b1;
                end
            end
            RUN: begin
                if (last_c) begin
                    cnt_nxt = '0;
                    if (bus.EN) begin
                        r_q_nxt    = div_clamp_c;
                        z_nxt      = 1'b1;
                        tick_nxt   = 1'b1;
                        active_nxt = 1'b1;
                    end else begin
                        state_nxt  = IDLE;
                        z_nxt      = 1'b0;
                        tick_nxt   = 1'b0;
                        active_nxt = 1'b0;
                    end
                end else begin
                    cnt_nxt  = cnt_inc_c[W-1:0];
                    z_nxt    = (cnt_inc_c < h_c);
                    tick_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt  = IDLE;
                cnt_nxt    = '0;
                z_nxt      = 1'b0;
                tick_nxt   = 1'b0;
                active_nxt = 1'b0;
            end
        endcase
    end

    assign bus.Z      = z;
    assign bus.TICK   = tick;
    assign bus.ACTIVE = active;
endmodule
